// File: rtl/regfile_scoreboard.sv
// Register file with write-through read bypass and per-register pending-write
// counters that stall issue on RAW hazards and counter saturation.
module regfile_scoreboard #(
  parameter int LEN_REGNO = 4,
  parameter int LEN_REG   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid,
  input  logic                      do_wb,
  input  logic [LEN_REGNO-1:0]      wb_regno,
  input  logic [LEN_REG-1:0]        wb_data,
  input  logic [LEN_REGNO-1:0]      rs_regno,
  input  logic [LEN_REGNO-1:0]      rt_regno,
  output logic [LEN_REG-1:0]        rs_data,
  output logic [LEN_REG-1:0]        rt_data,
  input  logic                      issue_valid,
  input  logic                      issue_use_rs,
  input  logic                      issue_use_rt,
  input  logic                      issue_is_wb,
  input  logic [LEN_REGNO-1:0]      issue_rd_regno,
  output logic                      issue_stall,
  input  logic                      flush,
  output logic [2**LEN_REGNO-1:0]   busy_o
);

  localparam int NREG = 2 ** LEN_REGNO;

  logic [LEN_REG-1:0] regs     [NREG];
  logic [1:0]         cnt      [NREG];
  logic [1:0]         cnt_next [NREG];

  logic wr_en;
  logic rs_ready;
  logic rt_ready;
  logic rd_full;
  logic accept;

  assign wr_en = wb_valid & do_wb;

  assign rs_data = (wr_en && wb_regno == rs_regno) ? wb_data : regs[rs_regno];
  assign rt_data = (wr_en && wb_regno == rt_regno) ? wb_data : regs[rt_regno];

  // A single outstanding write is satisfied by a writeback landing this cycle.
  assign rs_ready = (cnt[rs_regno] == 2'd0) ||
                    (cnt[rs_regno] == 2'd1 && wr_en && wb_regno == rs_regno);
  assign rt_ready = (cnt[rt_regno] == 2'd0) ||
                    (cnt[rt_regno] == 2'd1 && wr_en && wb_regno == rt_regno);
  assign rd_full  = (cnt[issue_rd_regno] == 2'd3);

  assign issue_stall = issue_valid & ((issue_use_rs & ~rs_ready) |
                                      (issue_use_rt & ~rt_ready) |
                                      (issue_is_wb  & rd_full));
  assign accept      = issue_valid & ~issue_stall & ~flush;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      logic inc;
      logic dec;
      inc = accept && issue_is_wb && issue_rd_regno == LEN_REGNO'(i);
      dec = wr_en && wb_regno == LEN_REGNO'(i) && cnt[i] != 2'd0;
      cnt_next[i] = cnt[i];
      if (inc && !dec) begin
        cnt_next[i] = cnt[i] + 2'd1;
      end else if (dec && !inc) begin
        cnt_next[i] = cnt[i] - 2'd1;
      end
    end
  end

  // Flush wipes bookkeeping only; the writeback itself still lands below.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= 2'd0;
      end
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wb_regno] <= wb_data;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_o[i] = (cnt[i] != 2'd0);
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed hazard scenarios plus
// randomized traffic compared against a pending-count reference model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, do_wb;
  logic [3:0]  wb_regno;
  logic [31:0] wb_data;
  logic [3:0]  rs_regno, rt_regno;
  logic [31:0] rs_data, rt_data;
  logic        issue_valid, issue_use_rs, issue_use_rt, issue_is_wb;
  logic [3:0]  issue_rd_regno;
  logic        issue_stall;
  logic        flush;
  logic [15:0] busy_o;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] mRegs [16];
  int          mCnt  [16];
  logic        obsStall;
  logic [31:0] obsRs;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .do_wb(do_wb), .wb_regno(wb_regno), .wb_data(wb_data),
    .rs_regno(rs_regno), .rt_regno(rt_regno), .rs_data(rs_data), .rt_data(rt_data),
    .issue_valid(issue_valid), .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
    .issue_is_wb(issue_is_wb), .issue_rd_regno(issue_rd_regno),
    .issue_stall(issue_stall), .flush(flush), .busy_o(busy_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic isReady(input int r, input logic w, input int wr);
    return (mCnt[r] == 0) || (mCnt[r] == 1 && w && wr == r);
  endfunction

  function automatic logic [31:0] expBusy();
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[i] = (mCnt[i] != 0);
    return b;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 16; i++) begin
      mRegs[i] = '0;
      mCnt[i]  = 0;
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic dw, input int wr, input logic [31:0] wd,
                               input int rs, input int rt, input logic iv, input logic urs,
                               input logic urt, input logic iwb, input int ird, input logic fl);
    logic        w, expStall, acc;
    logic [31:0] expRs, expRt;
    int          old [16];
    wb_valid = wv; do_wb = dw; wb_regno = 4'(wr); wb_data = wd;
    rs_regno = 4'(rs); rt_regno = 4'(rt);
    issue_valid = iv; issue_use_rs = urs; issue_use_rt = urt;
    issue_is_wb = iwb; issue_rd_regno = 4'(ird); flush = fl;
    #1;
    w        = wv & dw;
    expRs    = (w && wr == rs) ? wd : mRegs[rs];
    expRt    = (w && wr == rt) ? wd : mRegs[rt];
    expStall = iv & ((urs & ~isReady(rs, w, wr)) | (urt & ~isReady(rt, w, wr)) |
                     (iwb & (mCnt[ird] == 3)));
    checkOutput("rs_data", rs_data, expRs);
    checkOutput("rt_data", rt_data, expRt);
    checkOutput("issue_stall", {31'b0, issue_stall}, {31'b0, expStall});
    obsStall = issue_stall;
    obsRs    = rs_data;
    @(posedge clk);
    acc = iv & ~expStall & ~fl;
    old = mCnt;
    for (int i = 0; i < 16; i++) begin
      if (fl) begin
        mCnt[i] = 0;
      end else begin
        mCnt[i] = old[i] + ((acc && iwb && ird == i) ? 1 : 0)
                         - ((w && wr == i && old[i] != 0) ? 1 : 0);
      end
    end
    if (w) mRegs[wr] = wd;
    #1;
    checkOutput("busy_o", {16'b0, busy_o}, expBusy());
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asserts reset between edges and checks the asynchronous clear and bypass.
  task automatic midReset();
    rst = 1'b0;
    wb_valid = 0; do_wb = 0; flush = 0;
    issue_valid = 1; issue_use_rs = 1; issue_use_rt = 1; issue_is_wb = 1;
    rs_regno = 4'd4; rt_regno = 4'd3; issue_rd_regno = 4'd4;
    #1;
    checkOutput("rst_busy", {16'b0, busy_o}, 32'h0);
    checkOutput("rst_stall", {31'b0, issue_stall}, 32'h0);
    checkOutput("rst_rs", rs_data, 32'h0);
    checkOutput("rst_rt", rt_data, 32'h0);
    wb_valid = 1; do_wb = 1; wb_regno = 4'd3; wb_data = 32'h0000_00AA;
    #1;
    checkOutput("rst_bypass", rt_data, 32'h0000_00AA);
    clearModel();
    @(negedge clk);
    wb_valid = 0; do_wb = 0; issue_valid = 0;
    rst = 1'b1;
  endtask

  initial begin
    clearModel();
    rst = 1'b0;
    wb_valid = 0; do_wb = 0; wb_regno = 0; wb_data = 0;
    rs_regno = 0; rt_regno = 0; issue_valid = 0; issue_use_rs = 0;
    issue_use_rt = 0; issue_is_wb = 0; issue_rd_regno = 0; flush = 0;
    #2;
    checkOutput("reset_busy", {16'b0, busy_o}, 32'h0);
    checkOutput("reset_rs", rs_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Write-through bypass and persistence.
    applyStimulus(1, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("bypass_rs5", obsRs, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 32'h0, 5, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("held_rs5", obsRs, 32'hDEADBEEF);

    // RAW hazard resolved by a same-cycle writeback.
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 1, 3, 0);
    checkOutput("busy3_set", {31'b0, busy_o[3]}, 32'h1);
    applyStimulus(0, 0, 0, 32'h0, 3, 0, 1, 1, 0, 0, 0, 0);
    checkOutput("raw_stall", {31'b0, obsStall}, 32'h1);
    applyStimulus(1, 1, 3, 32'h0000_1234, 3, 0, 1, 1, 0, 0, 0, 0);
    checkOutput("raw_release", {31'b0, obsStall}, 32'h0);
    checkOutput("raw_bypass", obsRs, 32'h0000_1234);
    checkOutput("busy3_clear", {31'b0, busy_o[3]}, 32'h0);

    // Counter saturation and simultaneous inc/dec.
    repeat (3) applyStimulus(0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 1, 7, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 1, 7, 0);
    checkOutput("sat_stall", {31'b0, obsStall}, 32'h1);
    applyStimulus(1, 1, 7, 32'h7, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 7, 32'h77, 0, 0, 1, 0, 0, 1, 7, 0);
    checkOutput("waw_nostall", {31'b0, obsStall}, 32'h0);
    applyStimulus(1, 1, 7, 32'h777, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cnt7_one_left", {31'b0, busy_o[7]}, 32'h1);
    applyStimulus(1, 1, 7, 32'h7777, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cnt7_drained", {31'b0, busy_o[7]}, 32'h0);

    // Writeback with nothing pending must not underflow.
    applyStimulus(1, 1, 9, 32'h9999_0009, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("busy9_zero", {31'b0, busy_o[9]}, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 9, 0, 1, 1, 0, 0, 0, 0);
    checkOutput("reg9_nostall", {31'b0, obsStall}, 32'h0);

    // Flush drops bookkeeping but keeps the data write.
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 1, 2, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 1, 2, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 1, 4, 0);
    applyStimulus(1, 1, 4, 32'hCAFEF00D, 0, 0, 1, 0, 0, 1, 2, 1);
    checkOutput("flush_busy", {16'b0, busy_o}, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 4, 2, 0, 0, 0, 0, 0, 0);
    checkOutput("flush_reg4", obsRs, 32'hCAFEF00D);

    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 1, 4, 0);
    midReset();
    idle();

    for (int n = 0; n < 600; n++) begin
      int wr, rs, rt, ird;
      wr  = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
      rs  = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
      rt  = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
      ird = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), wr, $urandom,
                    rs, rt, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), ird,
                    1'($urandom_range(0, 29) == 0));
      if (n == 300) midReset();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
